ame_num_denormal: RTL



---
 rtl/ame_pkg.sv | 15 +
 rtl/ame_num_denormal_shl_stage.sv | 34 +++
 rtl/ame_num_denormal.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ame_pkg.sv
// Shared AME definitions: field width, saturation limits and the denormalizer FSM states.
package ame_pkg;

  localparam int unsigned AME_FIELD_BITS = 48;

  localparam logic [AME_FIELD_BITS-1:0] AME_POS_MAX = 48'h7FFF_FFFF_FFFF;
  localparam logic [AME_FIELD_BITS-1:0] AME_NEG_MAX = 48'h8000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINAL
  } ame_denorm_state_t;

endpackage

// File: rtl/ame_num_denormal_shl_stage.sv
// One log-step of the iterative left shifter: shift by step_i when enabled and
// report whether any significant bit (or the sign) would be lost.
// Optional macro: AME_DENORM_SAT_EN adds the overflow output.
module ame_shl_stage #(
  parameter int unsigned W  = 64,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic [W-1:0]  acc_i,
  input  logic [SW-1:0] step_i,
  input  logic          en_i,
`ifdef AME_DENORM_SAT_EN
  output logic          ovf_c,
`endif
  output logic [W-1:0]  acc_c
);

  // Zero-filled shift; pass through untouched when this stage's bit is clear.
  always_comb begin
    acc_c = en_i ? (acc_i << step_i) : acc_i;
  end

`ifdef AME_DENORM_SAT_EN
  // The top step_i+1 bits must all equal the sign for the shift to be exact.
  always_comb begin
    ovf_c = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (en_i && ((i + 32'(step_i)) >= (W - 1)) && (acc_i[i] != acc_i[W-1])) begin
        ovf_c = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ame_num_denormal.sv
// AME denormalizer: iterative saturating arithmetic left shift of a 48-bit
// signed field, one shift-amount bit per cycle, init/done handshake.
// Optional macro: AME_DENORM_SAT_EN (saturate on overflow, adds comp_sat_o);
// without it the result wraps to the low 48 bits, sign-extended.
module ame_num_denormal
  import ame_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               comp_init_i,
  output logic                               comp_busy_o,
  output logic                               comp_done_o,
  input  logic [$clog2(COMP_DATA_BITS)-1:0]  comp_shift_i,
  input  logic [COMP_DATA_BITS-1:0]          comp_data_i,
`ifdef AME_DENORM_SAT_EN
  output logic                               comp_sat_o,
`endif
  output logic [COMP_DATA_BITS-1:0]          comp_data_o
);

  localparam int unsigned W   = COMP_DATA_BITS;
  localparam int unsigned SW  = $clog2(COMP_DATA_BITS);
  localparam int unsigned FB  = AME_FIELD_BITS;
  localparam int unsigned EXT = W - FB;

  ame_denorm_state_t state_q, state_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [SW-1:0]     shamt_q, shamt_d;
  logic [SW-1:0]     k_q, k_d;
  logic [W-1:0]      data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef AME_DENORM_SAT_EN
  logic              sgn_q, sgn_d;
  logic              ovf_q, ovf_d;
  logic              sat_q, sat_d;
  logic              stage_ovf_c;
  logic [EXT:0]      top_c;
  logic              final_ovf_c;
`endif
  logic [W-1:0]      stage_acc_c;
  logic [SW-1:0]     stage_step_c;
  logic              stage_en_c;
  logic              unused_hi_c;

  // Bits above the 48-bit field are don't-care on input.
  assign unused_hi_c = ^comp_data_i[W-1:FB];

  // Current stage shifts by 2^k when bit k of the latched amount is set.
  assign stage_step_c = SW'(1) << k_q;
  assign stage_en_c   = shamt_q[k_q];

  ame_shl_stage #(
    .W  (W),
    .SW (SW)
  ) u_stage (
    .acc_i  (acc_q),
    .step_i (stage_step_c),
    .en_i   (stage_en_c),
`ifdef AME_DENORM_SAT_EN
    .ovf_c  (stage_ovf_c),
`endif
    .acc_c  (stage_acc_c)
  );

`ifdef AME_DENORM_SAT_EN
  // Result fits the 48-bit field only if bits [W-1:47] are all sign copies.
  assign top_c       = acc_q[W-1:FB-1];
  assign final_ovf_c = ovf_q | ~((&top_c) | ~(|top_c));
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shamt_d = shamt_q;
    k_d     = k_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef AME_DENORM_SAT_EN
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (comp_init_i) begin
          acc_d   = {{EXT{comp_data_i[FB-1]}}, comp_data_i[FB-1:0]};
          shamt_d = comp_shift_i;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef AME_DENORM_SAT_EN
          sgn_d   = comp_data_i[FB-1];
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        acc_d = stage_acc_c;
        k_d   = k_q + SW'(1);
`ifdef AME_DENORM_SAT_EN
        ovf_d = ovf_q | stage_ovf_c;
`endif
        if (k_q == SW'(SW - 1)) begin
          state_d = ST_FINAL;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_FINAL: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
`ifdef AME_DENORM_SAT_EN
        ovf_d = final_ovf_c;
        sat_d = final_ovf_c;
        if (final_ovf_c) begin
          data_d = sgn_q ? {{EXT{1'b1}}, AME_NEG_MAX} : {{EXT{1'b0}}, AME_POS_MAX};
        end else begin
          data_d = {{EXT{acc_q[FB-1]}}, acc_q[FB-1:0]};
        end
`else
        data_d = {{EXT{acc_q[FB-1]}}, acc_q[FB-1:0]};
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shamt_q <= '0;
      k_q     <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AME_DENORM_SAT_EN
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shamt_q <= shamt_d;
      k_q     <= k_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AME_DENORM_SAT_EN
      sgn_q   <= sgn_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
`endif
    end
  end

  assign comp_busy_o = busy_q;
  assign comp_done_o = done_q;
  assign comp_data_o = data_q;
`ifdef AME_DENORM_SAT_EN
  assign comp_sat_o  = sat_q;
`endif

endmodule
